// File: rtl/armcsr11.sv
// armcsr11: Unibus CSR slave whose PDP-visible registers are mirrored to an ARM core; PDP writes are logged in a FIFO for the ARM.
// Latency: ssyn_out_h and d_out_h are registered and assert one clock after a matching MSYN; armrdata is combinational.
// Backpressure: the Unibus slave stalls (no SSYN) while init_in_h or armwrite is high; a full FIFO drops pushes and sets overflow.
// Ports: CLOCK/RESET (async active-high); ARM side armwrite/armwaddr/armwdata/armraddr/armrdata/armintrq;
//        PDP interrupt intreq/irvec/intgnt/igvec; Unibus a_in_h/c_in_h/d_in_h/init_in_h/msyn_in_h -> d_out_h/ssyn_out_h.
module armcsr11 #(
    parameter logic [17:0]        ADDR     = 18'o774400,
    parameter logic [7:0]         INTVEC   = 8'o300,
    parameter int                 NREG     = 4,
    parameter logic [NREG*16-1:0] WRMASK   = '1,
    parameter int                 FIFOLOG2 = 3,
    parameter logic [15:0]        IDENT    = 16'h4143
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [3:0]  armraddr,
    input  logic [3:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        armintrq,
    output logic        intreq,
    output logic [7:0]  irvec,
    input  logic        intgnt,
    input  logic [7:0]  igvec,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        init_in_h,
    input  logic        msyn_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h
);
    localparam int              LG       = $clog2(NREG);
    localparam int              DEPTH    = 1 << FIFOLOG2;
    localparam logic [11:0]     VERSION  = 12'h011;
    localparam logic [4:0]      NREG5    = 5'(NREG);
    localparam logic [FIFOLOG2:0] CNT_FULL = {1'b1, {FIFOLOG2{1'b0}}};

    logic                enable, initflag, overflow, intpend, init_d;
    logic [15:0]         regs     [NREG];
    // FIFO entry: {regidx[2:0], writehi, writelo, data[15:0]}
    logic [20:0]         fifo_mem [DEPTH];
    logic [FIFOLOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFOLOG2:0]   count, count_nxt;

    // Unibus decode
    logic          match, ub_go, ub_wr, ub_rd, writehi, writelo, full, push_ok, pop, ovf_set;
    logic [LG-1:0] ub_idx;
    logic [15:0]   ub_mask;

    assign match   = enable && ((a_in_h >> (LG + 1)) == (ADDR >> (LG + 1)));
    assign ub_idx  = a_in_h[LG:1];
    assign writehi = ~c_in_h[0] | a_in_h[0];
    assign writelo = ~c_in_h[0] | ~a_in_h[0];
    assign ub_mask = {{8{writehi}}, {8{writelo}}} & WRMASK[16*ub_idx +: 16];
    // ssyn_out_h already high means this MSYN was serviced; wait for MSYN to drop
    assign ub_go   = !init_in_h && !armwrite && msyn_in_h && match && !ssyn_out_h;
    assign ub_wr   = ub_go && c_in_h[1];
    assign ub_rd   = ub_go && !c_in_h[1];

    // ARM write decode
    logic          arm_wr, arm_reg_wr;
    logic [3:0]    wr_off, rd_off;
    assign arm_wr     = armwrite && !init_in_h;
    assign wr_off     = armwaddr - 4'd4;
    assign arm_reg_wr = arm_wr && (armwaddr >= 4'd4) && ({1'b0, wr_off} < NREG5);

    // FIFO control
    assign full    = (count == CNT_FULL);
    assign pop     = arm_wr && (armwaddr == 4'd3) && (count != '0);
    assign push_ok = ub_wr && (!full || pop);
    assign ovf_set = ub_wr && full && !pop;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // ARM read map
    assign rd_off = armraddr - 4'd4;
    always_comb begin
        armrdata = '0;
        case (armraddr)
            4'd0: armrdata = {IDENT, 4'(LG - 1), VERSION};
            4'd1: armrdata = {enable, initflag, overflow, intpend, 7'b0, 5'(count), 8'b0, INTVEC};
            4'd2: if (count != '0)
                      armrdata = {1'b1, 8'b0, fifo_mem[rd_ptr][20:16], 2'b0, fifo_mem[rd_ptr][15:0]};
            default:
                if ((armraddr >= 4'd4) && ({1'b0, rd_off} < NREG5))
                    armrdata = {16'b0, regs[rd_off[LG-1:0]]};
        endcase
    end

    assign armintrq = (count != '0) | initflag;
    assign intreq   = intpend;
    assign irvec    = INTVEC;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            enable     <= 1'b0;
            initflag   <= 1'b0;
            overflow   <= 1'b0;
            intpend    <= 1'b0;
            init_d     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            d_out_h    <= '0;
            ssyn_out_h <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            init_d <= init_in_h;
            if (init_in_h) begin
                for (int i = 0; i < NREG; i++) regs[i] <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                intpend    <= 1'b0;
                d_out_h    <= '0;
                ssyn_out_h <= 1'b0;
            end else begin
                if (arm_wr && (armwaddr == 4'd1)) begin
                    enable <= armwdata[31];
                    if (armwdata[30]) initflag <= 1'b0;
                    if (armwdata[29]) overflow <= 1'b0;
                end
                // falling edge of init: set after any clear so it is never lost
                if (init_d) initflag <= 1'b1;

                // ARM set wins over a simultaneous matching grant
                if (arm_wr && (armwaddr == 4'd1) && armwdata[28])
                    intpend <= 1'b1;
                else if (intgnt && (igvec == INTVEC))
                    intpend <= 1'b0;

                if (arm_reg_wr)
                    regs[wr_off[LG-1:0]] <= (regs[wr_off[LG-1:0]] & ~armwdata[31:16])
                                          | (armwdata[15:0] & armwdata[31:16]);
                if (ub_wr)
                    regs[ub_idx] <= (regs[ub_idx] & ~ub_mask) | (d_in_h & ub_mask);

                if (push_ok) begin
                    fifo_mem[wr_ptr] <= {3'(ub_idx), writehi, writelo, d_in_h};
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
                if (ovf_set) overflow <= 1'b1;

                if (!msyn_in_h) begin
                    ssyn_out_h <= 1'b0;
                    d_out_h    <= '0;
                end else if (ub_go) begin
                    ssyn_out_h <= 1'b1;
                    if (ub_rd) d_out_h <= regs[ub_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_armcsr11.sv
// tb_armcsr11: scoreboard bench for armcsr11 (NREG=4, FIFO depth 2, register 2 low-byte writable only).
// Latency: expects SSYN one clock after MSYN and combinational ARM reads.
// Backpressure: exercises disabled decode, ARM-write stalls, FIFO overflow, INIT and async RESET.
module tb_armcsr11;
    logic        CLOCK = 1'b0, RESET = 1'b1;
    logic        armwrite = 1'b0, intgnt = 1'b0, init_in_h = 1'b0, msyn_in_h = 1'b0;
    logic [3:0]  armraddr = '0, armwaddr = '0;
    logic [31:0] armwdata = '0, armrdata;
    logic        armintrq, intreq, ssyn_out_h;
    logic [7:0]  irvec, igvec = '0;
    logic [17:0] a_in_h = '0;
    logic [1:0]  c_in_h = '0;
    logic [15:0] d_in_h = '0, d_out_h;

    armcsr11 #(
        .ADDR(18'o774400), .INTVEC(8'o300), .NREG(4),
        .WRMASK(64'hFFFF_00FF_FFFF_FFFF), .FIFOLOG2(1), .IDENT(16'h4143)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr), .armwdata(armwdata),
        .armrdata(armrdata), .armintrq(armintrq),
        .intreq(intreq), .irvec(irvec), .intgnt(intgnt), .igvec(igvec),
        .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h), .init_in_h(init_in_h),
        .msyn_in_h(msyn_in_h), .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk = 0, n_err = 0;

    // reference model
    logic [15:0] reg_m    [4];
    logic [15:0] wrmask_m [4] = '{16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF};
    logic        en_m = 0, initf_m = 0, ovf_m = 0, intp_m = 0;
    logic [31:0] fifo_q [$];
    logic [31:0] rd_q   [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic arm_rd(input logic [3:0] a, output logic [31:0] d);
        armraddr = a;
        #1;
        d = armrdata;
    endtask

    task automatic arm_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge CLOCK);
        armwrite = 1'b1; armwaddr = a; armwdata = d;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic chk_stat(input string tag);
        logic [31:0] d;
        arm_rd(4'd1, d);
        chk(tag, d, {en_m, initf_m, ovf_m, intp_m, 7'b0, 5'(fifo_q.size()), 8'b0, 8'hC0});
    endtask

    task automatic chk_head(input string tag);
        logic [31:0] d;
        arm_rd(4'd2, d);
        chk(tag, d, (fifo_q.size() != 0) ? fifo_q[0] : 32'h0);
    endtask

    task automatic chk_reg(input string tag, input int i);
        logic [31:0] d;
        arm_rd(4'(4 + i), d);
        chk(tag, d, {16'h0, reg_m[i]});
    endtask

    task automatic arm_pop();
        arm_wr(4'd3, 32'h0);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    endtask

    // one bus cycle; lat = clocks until SSYN, -1 if none within max_wait
    task automatic ub_cycle(input logic [17:0] addr, input logic [1:0] c, input logic [15:0] data,
                            input int max_wait, input string tag, output int lat);
        logic [31:0] exp;
        @(negedge CLOCK);
        a_in_h = addr; c_in_h = c; d_in_h = data; msyn_in_h = 1'b1;
        lat = -1;
        for (int i = 1; i <= max_wait; i++) begin
            @(negedge CLOCK);
            if (ssyn_out_h) begin
                lat = i;
                break;
            end
        end
        if (!c[1] && rd_q.size() != 0) begin
            exp = rd_q.pop_front();
            if (lat > 0) chk({tag, "_dout"}, {16'h0, d_out_h}, exp);
        end
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        chk({tag, "_ssyn_off"}, {31'b0, ssyn_out_h}, 32'h0);
        chk({tag, "_dout_off"}, {16'h0, d_out_h}, 32'h0);
    endtask

    task automatic pdp_write(input logic [17:0] addr, input logic bytew, input logic [15:0] data,
                             input string tag);
        logic hi, lo;
        logic [1:0] idx;
        logic [15:0] m;
        int lat;
        hi  = bytew ? addr[0] : 1'b1;
        lo  = bytew ? ~addr[0] : 1'b1;
        idx = addr[2:1];
        m   = {{8{hi}}, {8{lo}}} & wrmask_m[idx];
        reg_m[idx] = (reg_m[idx] & ~m) | (data & m);
        if (fifo_q.size() < 2) fifo_q.push_back({1'b1, 8'b0, 1'b0, idx, hi, lo, 2'b00, data});
        else ovf_m = 1'b1;
        ub_cycle(addr, {1'b1, bytew}, data, 4, tag, lat);
        chk({tag, "_lat"}, lat, 1);
    endtask

    task automatic pdp_read(input logic [17:0] addr, input string tag);
        int lat;
        rd_q.push_back({16'h0, reg_m[addr[2:1]]});
        ub_cycle(addr, 2'b00, 16'h0, 4, tag, lat);
        chk({tag, "_lat"}, lat, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int lat;
        for (int i = 0; i < 4; i++) reg_m[i] = '0;

        // reset state
        #12;
        chk("rst_ssyn", {31'b0, ssyn_out_h}, 0);
        chk("rst_dout", {16'h0, d_out_h}, 0);
        chk("rst_intreq", {31'b0, intreq}, 0);
        chk("rst_armintrq", {31'b0, armintrq}, 0);
        chk("irvec", {24'h0, irvec}, 32'hC0);
        chk_stat("rst_stat");
        arm_rd(4'd0, d);
        chk("ident", d, 32'h4143_1011);
        @(negedge CLOCK);
        RESET = 1'b0;

        // disabled: no response
        ub_cycle(18'o774406, 2'b00, 16'h0, 5, "dis", lat);
        chk("dis_nossyn", lat, -1);

        arm_wr(4'd1, 32'h8000_0000);
        en_m = 1'b1;
        chk_stat("en_stat");

        // word write to reg1
        pdp_write(18'o774402, 1'b0, 16'o123456, "dato1");
        chk_reg("reg1", 1);
        chk_head("head1");
        chk("armintrq_fifo", {31'b0, armintrq}, 1);
        chk_stat("stat_c1");

        // odd byte write into masked lane of reg2
        pdp_write(18'o774405, 1'b1, 16'hAA00, "datob");
        chk_reg("reg2_masked", 2);
        chk_stat("stat_c2");

        // overflow: register updates, entry dropped
        pdp_write(18'o774400, 1'b0, 16'h1234, "dato_ovf");
        chk_reg("reg0_ovf", 0);
        chk_stat("stat_ovf");

        // drain with head checks
        chk_head("head_a");
        arm_pop();
        chk_stat("stat_pop1");
        chk_head("head_b");
        arm_pop();
        chk_head("head_empty");
        arm_pop();
        chk_stat("stat_empty");
        chk("armintrq_idle", {31'b0, armintrq}, 0);
        arm_wr(4'd1, 32'hA000_0000);
        ovf_m = 1'b0;
        chk_stat("ovf_clr");

        // ARM register writes with bit enables
        arm_wr(4'd7, 32'hFFFF_5A5A);
        reg_m[3] = 16'h5A5A;
        arm_wr(4'd7, 32'h00FF_1234);
        reg_m[3] = 16'h5A34;
        chk_reg("reg3_arm", 3);
        arm_wr(4'd6, 32'hFFFF_BEEF);
        reg_m[2] = 16'hBEEF;
        chk_reg("reg2_arm", 2);

        pdp_read(18'o774402, "dati1");
        pdp_read(18'o774404, "dati2");

        // ARM write stalls the bus
        rd_q.push_back({16'h0, reg_m[3]});
        @(negedge CLOCK);
        armwrite = 1'b1; armwaddr = 4'd0; armwdata = 32'h0;
        a_in_h = 18'o774406; c_in_h = 2'b00; msyn_in_h = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            chk("stall_ssyn", {31'b0, ssyn_out_h}, 0);
        end
        armwrite = 1'b0;
        @(negedge CLOCK);
        chk("stall_release", {31'b0, ssyn_out_h}, 1);
        chk("stall_dout", {16'h0, d_out_h}, rd_q.pop_front());
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        chk("stall_ssyn_off", {31'b0, ssyn_out_h}, 0);

        // PDP interrupt
        arm_wr(4'd1, 32'h9000_0000);
        intp_m = 1'b1;
        chk("intreq_set", {31'b0, intreq}, 1);
        intgnt = 1'b1; igvec = 8'o301;
        @(negedge CLOCK);
        chk("intreq_wrongvec", {31'b0, intreq}, 1);
        igvec = 8'o300;
        armwrite = 1'b1; armwaddr = 4'd1; armwdata = 32'h9000_0000;
        @(negedge CLOCK);
        armwrite = 1'b0;
        chk("intreq_setwins", {31'b0, intreq}, 1);
        @(negedge CLOCK);
        chk("intreq_gnt", {31'b0, intreq}, 0);
        intp_m = 1'b0;
        intgnt = 1'b0;

        // INIT mid-FIFO
        pdp_write(18'o774404, 1'b0, 16'h0055, "dato_pre_init");
        chk_stat("stat_pre_init");
        @(negedge CLOCK);
        init_in_h = 1'b1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        init_in_h = 1'b0;
        for (int i = 0; i < 4; i++) reg_m[i] = '0;
        fifo_q.delete();
        @(negedge CLOCK);
        initf_m = 1'b1;
        chk_stat("stat_post_init");
        chk_reg("reg2_init", 2);
        chk_reg("reg1_init", 1);
        chk("armintrq_initflag", {31'b0, armintrq}, 1);
        arm_wr(4'd1, 32'hC000_0000);
        initf_m = 1'b0;
        chk("armintrq_clr", {31'b0, armintrq}, 0);
        pdp_read(18'o774402, "dati_post_init");

        // async RESET mid-cycle
        @(negedge CLOCK);
        a_in_h = 18'o774402; c_in_h = 2'b00; msyn_in_h = 1'b1;
        @(negedge CLOCK);
        chk("pre_rst_ssyn", {31'b0, ssyn_out_h}, 1);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_ssyn", {31'b0, ssyn_out_h}, 0);
        en_m = 1'b0;
        chk_stat("async_rst_stat");
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/armcsr11.md
ARMCSR11 -- requirements
Module: armcsr11

Interface
REQ-001 SHALL have parameter ADDR, default 18'o774400: Unibus base address, aligned to 2*NREG bytes.
REQ-002 SHALL have parameter INTVEC, default 8'o300: interrupt vector.
REQ-003 SHALL have parameter NREG, default 4: PDP-visible 16-bit registers, power of 2 in 2..8.
REQ-004 SHALL have parameter WRMASK, NREG*16 bits, default all ones: PDP-writable bit mask; register i uses bits [16i+15:16i].
REQ-005 SHALL have parameter FIFOLOG2, default 3: PDP-write FIFO depth = 2**FIFOLOG2, 1..4.
REQ-006 SHALL have parameter IDENT, default 16'h4143: ARM identification code.
REQ-007 SHALL have the ports: CLOCK in 1, system clock; RESET in 1, asynchronous active-high reset.
REQ-008 SHALL have the ARM ports: armwrite in 1, write strobe; armraddr in 4, read address; armwaddr in 4, write address; armwdata in 32, write data; armrdata out 32, combinational read data; armintrq out 1, ARM wakeup.
REQ-009 SHALL have the interrupt ports: intreq out 1, PDP interrupt request; irvec out 8, vector, always INTVEC; intgnt in 1, grant; igvec in 8, granted vector.
REQ-010 SHALL have the Unibus inputs: a_in_h in 18, address; c_in_h in 2, C1/C0; d_in_h in 16, write data; init_in_h in 1, bus INIT; msyn_in_h in 1, master sync.
REQ-011 SHALL have the Unibus outputs: d_out_h out 16, registered read data; ssyn_out_h out 1, registered slave sync.

Function
REQ-012 SHALL define the ARM read map as:
- 0: {IDENT, log2(NREG)-1 in [15:12], version in [11:0]}.
- 1: {enable, initflag, overflow, intpend, 7'b0, fifo count in [20:16], 8'b0, INTVEC}.
- 2: FIFO head {valid, 8'b0, regidx[2:0], writehi, writelo, 2'b0, data[15:0]}; all zero when empty.
- 4+i: register i in [15:0], for i < NREG.
- All other addresses: 0.
REQ-013 SHALL decode ARM writes as:
- 1: enable <= [31]; [30]=1 clears initflag; [29]=1 clears overflow; [28]=1 sets intpend.
- 3: any data pops one FIFO entry; ignored when empty.
- 4+i: register bits where [31:16] is 1 load from [15:0], regardless of WRMASK.
REQ-014 SHALL match the Unibus address when enable is 1 and a_in_h[17:log2(NREG)+1] equals the same ADDR bits; register index = a_in_h[log2(NREG):1].
REQ-015 SHALL return d_out_h to 0 and ssyn_out_h to 0 on the next clock whenever msyn_in_h is 0.
REQ-016 SHALL, when msyn_in_h is 1, the address matches and ssyn_out_h is 0, set ssyn_out_h to 1 one clock later and service exactly one access per MSYN assertion.
REQ-017 SHALL, on a read (c_in_h[1]=0), load d_out_h with the selected register in the same edge that sets ssyn_out_h.
REQ-018 SHALL apply byte lanes on a write (c_in_h[1]=1): writehi = ~c_in_h[0] | a_in_h[0]; writelo = ~c_in_h[0] | ~a_in_h[0].
REQ-019 SHALL, on a write, update only bits that are both in an enabled lane and set in WRMASK.
REQ-020 SHALL, on every PDP write, push {regidx, writehi, writelo, d_in_h} into the FIFO.
REQ-021 SHALL handle the FIFO as follows:
- A push and a pop in the same cycle are both performed.
- A push when full without a pop drops the entry and sets sticky overflow; the register update still occurs.
- Count range is 0..2**FIFOLOG2; pointers wrap modulo depth.
REQ-022 SHALL drive armintrq = (fifo count != 0) | initflag.
REQ-023 SHALL drive intreq = intpend; intpend clears on a clock where intgnt=1 and igvec=INTVEC; a simultaneous ARM set wins.
REQ-024 SHALL apply per-clock priority: init_in_h, then armwrite, then Unibus; a stalled bus access completes on a later clock while MSYN is held.

Reset
REQ-025 SHALL, while RESET is 1 (asynchronous), hold all registers at 0, including enable, the FIFO pointers and count, overflow, intpend, initflag, d_out_h and ssyn_out_h.
REQ-026 SHALL, while init_in_h is 1, clear the PDP registers, FIFO, overflow, intpend, d_out_h and ssyn_out_h, and preserve enable.
REQ-027 SHALL set initflag on the first clock after init_in_h falls.

Verification
REQ-028 SHALL cover: enable=1, NREG=4, ADDR=774400, DATO 774402 = 16'o123456 -> ssyn 1 clock later; reg1=123456; FIFO head={1,..,idx1,1,1,123456}; armintrq=1.
REQ-029 SHALL cover: DATOB 774405 = 8'o252 with WRMASK reg2=16'h00FF -> reg2 unchanged; FIFO entry writehi=1, writelo=0.
REQ-030 SHALL cover: FIFOLOG2=1, three writes with no pop -> count=2, overflow=1, third register value updated; one pop -> count=1.
REQ-031 SHALL cover: ARM writes address 1 with [28]=1 -> intreq=1; intgnt with igvec=INTVEC -> intreq=0 next clock; igvec != INTVEC -> intreq stays 1.
REQ-032 SHALL cover: init pulse mid-FIFO with enable=1 -> FIFO empty, regs 0, enable=1, initflag=1 after release; async RESET mid-cycle -> ssyn_out_h=0 immediately.
REQ-033 SHALL cover: DATI 774406 with enable=0 -> no ssyn_out_h; with armwrite held high -> ssyn_out_h delayed until armwrite=0.
